// File: rtl/jit_pkg.sv
// Shared types and constants for the JVM-to-ARM bytecode translator.
package jit_pkg;

  typedef enum logic [1:0] {
    FETCH_OP,
    DECODE,
    FETCH_PARAM,
    EMIT
  } state_e;

  localparam logic [7:0] OPC_WIDE    = 8'hC4;  // JVM 'wide' prefix
  localparam logic [2:0] CNT_UNKNOWN = 3'd7;   // lookup ROM marker for unknown opcodes
  localparam int         UADDR_END   = 0;      // microcode "no entry" / end of chain
  localparam int         PATCH_LSB   = 0;      // operand field position in ARM word
  localparam int         PATCH_W     = 12;     // operand field width in ARM word

endpackage

// File: rtl/jit_operand_patch.sv
// Merges the collected operand into a microcode template word and flags
// operands that do not fit in the patch field.
module jit_operand_patch
  import jit_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int OP_W   = 32
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [OP_W-1:0]   operand_i,
  input  logic              patch_i,
  output logic [WORD_W-1:0] word_o,
  output logic              range_err_o
);

  // Replace the operand field of the template when the word is flagged.
  always_comb begin
    word_o = word_i;
    if (patch_i) word_o[PATCH_LSB +: PATCH_W] = operand_i[PATCH_W-1:0];
  end

  // Any set bit above the field means the emitted value is truncated.
  assign range_err_o = patch_i && (|operand_i[OP_W-1:PATCH_W]);

endmodule

// File: rtl/jit_bytecode_translator.sv
// JVM bytecode to ARM translator: fetches opcode and operand bytes, then
// walks a chained microcode ROM emitting (optionally patched) ARM words.
module jit_bytecode_translator
  import jit_pkg::*;
#(
  parameter int UADDR_W = 8,
  parameter int WORD_W  = 32,
  parameter int MAX_OPS = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic [7:0]         lk_opcode,
  input  logic [2:0]         lk_count,
  input  logic [UADDR_W-1:0] lk_entry,
  output logic [UADDR_W-1:0] uc_addr,
  input  logic [WORD_W-1:0]  uc_word,
  input  logic [UADDR_W-1:0] uc_next,
  input  logic               uc_patch,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_word,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_unknown,
  output logic               err_range,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int OP_W = 8 * MAX_OPS;
  localparam logic [UADDR_W-1:0] END_ADDR = UADDR_W'(UADDR_END);

  state_e             state_q, state_d;
  logic [7:0]         opcode_q, opcode_d;
  logic               wide_q, wide_d;
  logic [OP_W-1:0]    operand_q, operand_d;
  logic [3:0]         remaining_q, remaining_d;
  logic [UADDR_W-1:0] uc_addr_q, uc_addr_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               err_range_q, err_range_d;

  logic [3:0]         n_ops;
  logic [WORD_W-1:0]  patched_word;
  logic               patch_range_err;

  jit_operand_patch #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W)
  ) u_patch (
    .word_i      (uc_word),
    .operand_i   (operand_q),
    .patch_i     (uc_patch),
    .word_o      (patched_word),
    .range_err_o (patch_range_err)
  );

  // Operand byte count, doubled under a preceding 'wide' prefix.
  assign n_ops = wide_q ? {lk_count, 1'b0} : {1'b0, lk_count};

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_OP;
      opcode_q      <= '0;
      wide_q        <= 1'b0;
      operand_q     <= '0;
      remaining_q   <= '0;
      uc_addr_q     <= '0;
      instr_count_q <= '0;
      err_range_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      wide_q        <= wide_d;
      operand_q     <= operand_d;
      remaining_q   <= remaining_d;
      uc_addr_q     <= uc_addr_d;
      instr_count_q <= instr_count_d;
      err_range_q   <= err_range_d;
    end
  end

  // Next-state and handshake outputs; flush overrides everything at the end.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d       = state_q;
    opcode_d      = opcode_q;
    wide_d        = wide_q;
    operand_d     = operand_q;
    remaining_d   = remaining_q;
    uc_addr_d     = uc_addr_q;
    instr_count_d = instr_count_q;
    err_range_d   = err_range_q;
    byte_ready    = 1'b0;
    out_valid     = 1'b0;
    err_unknown   = 1'b0;

    case (state_q)
      FETCH_OP: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          opcode_d = byte_data;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (opcode_q == OPC_WIDE) begin
          wide_d  = 1'b1;
          state_d = FETCH_OP;
        end else if (lk_count == CNT_UNKNOWN || int'(n_ops) > MAX_OPS) begin
          err_unknown = 1'b1;
          wide_d      = 1'b0;
          state_d     = FETCH_OP;
        end else if (n_ops == 4'd0) begin
          uc_addr_d = lk_entry;
          operand_d = '0;
          state_d   = EMIT;
        end else begin
          remaining_d = n_ops;
          operand_d   = '0;
          state_d     = FETCH_PARAM;
        end
      end
      FETCH_PARAM: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          operand_d   = {operand_q[OP_W-9:0], byte_data};
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            uc_addr_d = lk_entry;
            state_d   = EMIT;
          end
        end
      end
      EMIT: begin
        if (uc_addr_q == END_ADDR) begin
          instr_count_d = instr_count_q + CNT_W'(1);
          wide_d        = 1'b0;
          state_d       = FETCH_OP;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            if (patch_range_err) err_range_d = 1'b1;
            if (uc_next != END_ADDR) begin
              uc_addr_d = uc_next;
            end else begin
              instr_count_d = instr_count_q + CNT_W'(1);
              wide_d        = 1'b0;
              state_d       = FETCH_OP;
            end
          end
        end
      end
      default: state_d = FETCH_OP;
    endcase

    // Abort: discard the partial instruction and any same-edge transfer.
    if (flush) begin
      state_d       = FETCH_OP;
      wide_d        = 1'b0;
      remaining_d   = '0;
      opcode_d      = opcode_q;
      operand_d     = operand_q;
      uc_addr_d     = uc_addr_q;
      instr_count_d = instr_count_q;
      err_range_d   = err_range_q;
      err_unknown   = 1'b0;
    end
  end

  assign lk_opcode   = opcode_q;
  assign uc_addr     = uc_addr_q;
  assign out_word    = out_valid ? patched_word : '0;
  assign busy        = (state_q != FETCH_OP);
  assign err_range   = err_range_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_jit_bytecode_translator.sv
// Scoreboard bench for the bytecode translator with behavioural lookup and
// microcode ROMs.
module tb_jit_bytecode_translator;

  localparam int UADDR_W = 8;
  localparam int WORD_W  = 32;
  localparam int MAX_OPS = 4;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic [7:0]         lk_opcode;
  logic [2:0]         lk_count;
  logic [UADDR_W-1:0] lk_entry;
  logic [UADDR_W-1:0] uc_addr;
  logic [WORD_W-1:0]  uc_word;
  logic [UADDR_W-1:0] uc_next;
  logic               uc_patch;
  logic               out_valid;
  logic [WORD_W-1:0]  out_word;
  logic               out_ready;
  logic               busy;
  logic               err_unknown;
  logic               err_range;
  logic [CNT_W-1:0]   instr_count;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int unk_cycles = 0;
  logic [WORD_W-1:0] exp_q[$];

  jit_bytecode_translator #(
    .UADDR_W (UADDR_W),
    .WORD_W  (WORD_W),
    .MAX_OPS (MAX_OPS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .lk_opcode   (lk_opcode),
    .lk_count    (lk_count),
    .lk_entry    (lk_entry),
    .uc_addr     (uc_addr),
    .uc_word     (uc_word),
    .uc_next     (uc_next),
    .uc_patch    (uc_patch),
    .out_valid   (out_valid),
    .out_word    (out_word),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_unknown (err_unknown),
    .err_range   (err_range),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Opcode lookup ROM.
  always_comb begin
    lk_count = 3'd7;
    lk_entry = 8'h00;
    case (lk_opcode)
      8'h00: begin lk_count = 3'd0; lk_entry = 8'h00; end  // entry 0: no output
      8'h04: begin lk_count = 3'd0; lk_entry = 8'h40; end  // 3-word chain
      8'h10: begin lk_count = 3'd1; lk_entry = 8'h20; end  // bipush
      8'h11: begin lk_count = 3'd2; lk_entry = 8'h38; end  // sipush
      8'h12: begin lk_count = 3'd3; lk_entry = 8'h20; end  // 3 bytes: too many under wide
      8'h15: begin lk_count = 3'd1; lk_entry = 8'h30; end  // iload
      8'hC4: begin lk_count = 3'd0; lk_entry = 8'h00; end
      default: ;
    endcase
  end

  // Microcode ROM.
  always_comb begin
    uc_word  = 32'h0;
    uc_next  = 8'h00;
    uc_patch = 1'b0;
    case (uc_addr)
      8'h20: begin uc_word = 32'hE3A00000; uc_patch = 1'b1; end
      8'h30: begin uc_word = 32'hE59B0000; uc_patch = 1'b1; end
      8'h38: begin uc_word = 32'hE3A01000; uc_patch = 1'b1; end
      8'h40: begin uc_word = 32'hE1A00000; uc_next = 8'h41; end
      8'h41: begin uc_word = 32'hE2811001; uc_next = 8'h42; end
      8'h42: begin uc_word = 32'hE3A02000; uc_patch = 1'b1; end
      default: ;
    endcase
  end

  // Scoreboard: a word seen valid and ready at the falling edge transfers on
  // the next rising edge unless flush or reset blocks it.
  always @(negedge clk) begin
    if (err_unknown) unk_cycles++;
    if (rst_n && !flush && out_valid && out_ready) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard unexpected word: got %08h, expected none", out_word);
      end else begin
        logic [WORD_W-1:0] e;
        e = exp_q.pop_front();
        if (out_word !== e) begin
          errors++;
          $display("FAIL scoreboard word: got %08h, expected %08h", out_word, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (!byte_ready) begin
      errors++;
      $display("FAIL send_byte %02h: byte_ready got 0, expected 1 within 50 cycles", b);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < 100) begin
      tick();
      w++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s idle: busy=%0b pending=%0d, expected busy=0 pending=0",
               name, busy, exp_q.size());
    end
  endtask

  task automatic check_count(input string name, input int exp);
    checks++;
    if (instr_count !== CNT_W'(exp)) begin
      errors++;
      $display("FAIL %s instr_count: got %0d, expected %0d", name, instr_count, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err_unknown !== 1'b0 || err_range !== 1'b0 ||
        instr_count !== '0 || uc_addr !== '0 || lk_opcode !== '0 || out_word !== '0 ||
        byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset state: ov=%0b busy=%0b eu=%0b er=%0b cnt=%0d ua=%02h op=%02h ow=%08h br=%0b, expected all 0 and br=1",
               out_valid, busy, err_unknown, err_range, instr_count, uc_addr, lk_opcode, out_word, byte_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bipush();
    exp_q.push_back(32'hE3A00005);
    send_byte(8'h10);
    send_byte(8'h05);
    wait_idle("bipush");
    check_count("bipush", 1);
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL bipush byte_ready: got %0b, expected 1", byte_ready);
    end
  endtask

  task automatic test_wide();
    exp_q.push_back(32'hE59B0102);
    send_byte(8'hC4); send_byte(8'h15); send_byte(8'h01); send_byte(8'h02);
    wait_idle("wide");
    check_count("wide", 2);
    // A lone iload must now take a single operand byte.
    exp_q.push_back(32'hE59B0007);
    send_byte(8'h15); send_byte(8'h07);
    wait_idle("wide_cleared");
    check_count("wide_cleared", 3);
    // Wide sipush: 4 operand bytes reach MAX_OPS exactly; value fits.
    exp_q.push_back(32'hE3A01123);
    send_byte(8'hC4); send_byte(8'h11);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h23);
    wait_idle("wide_max");
    check_count("wide_max", 4);
    // Wide after wide keeps the flag.
    exp_q.push_back(32'hE59B0009);
    send_byte(8'hC4); send_byte(8'hC4); send_byte(8'h15); send_byte(8'h00); send_byte(8'h09);
    wait_idle("wide_wide");
    check_count("wide_wide", 5);
    checks++;
    if (err_range !== 1'b0 || unk_cycles != 0) begin
      errors++;
      $display("FAIL wide errors: err_range=%0b unk_cycles=%0d, expected 0 and 0", err_range, unk_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int stable_bad = 0;
    int acc0;
    out_ready = 1'b0;
    exp_q.push_back(32'hE1A00000);
    exp_q.push_back(32'hE2811001);
    exp_q.push_back(32'hE3A02000);
    send_byte(8'h04);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || lk_opcode !== 8'h04) begin
      errors++;
      $display("FAIL latency decode: ov=%0b busy=%0b op=%02h, expected 0 1 04", out_valid, busy, lk_opcode);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_word !== 32'hE1A00000) stable_bad++;
      tick();
    end
    checks++;
    if (stable_bad != 0) begin
      errors++;
      $display("FAIL hold stable: %0d bad cycles, expected 0 (last ov=%0b word=%08h)", stable_bad, out_valid, out_word);
    end
    acc0 = acc_cnt;
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (acc_cnt - acc0 != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: accepted %0d busy=%0b, expected 3 and 0", acc_cnt - acc0, busy);
    end
    check_count("back_to_back", 6);
  endtask

  task automatic test_unknown();
    unk_cycles = 0;
    send_byte(8'hFF);
    tick(); tick(); tick();
    checks++;
    if (unk_cycles != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL unknown pulse: %0d cycles busy=%0b, expected 1 and 0", unk_cycles, busy);
    end
    send_byte(8'h00);
    wait_idle("entry0");
    check_count("entry0", 7);
    // Wide with a 3-byte opcode asks for 6 > MAX_OPS bytes.
    send_byte(8'hC4); send_byte(8'h12);
    tick(); tick();
    exp_q.push_back(32'hE3A00003);
    send_byte(8'h10); send_byte(8'h03);
    wait_idle("wide_over");
    check_count("wide_over", 8);
    checks++;
    if (unk_cycles != 2) begin
      errors++;
      $display("FAIL wide_over pulse: %0d cycles, expected 2", unk_cycles);
    end
  endtask

  task automatic test_range();
    exp_q.push_back(32'hE3A01234);
    send_byte(8'h11); send_byte(8'h12); send_byte(8'h34);
    wait_idle("range");
    checks++;
    if (err_range !== 1'b1) begin
      errors++;
      $display("FAIL range set: got %0b, expected 1", err_range);
    end
    exp_q.push_back(32'hE3A00005);
    send_byte(8'h10); send_byte(8'h05);
    wait_idle("range_sticky");
    check_count("range_sticky", 10);
    checks++;
    if (err_range !== 1'b1) begin
      errors++;
      $display("FAIL range sticky: got %0b, expected 1", err_range);
    end
  endtask

  task automatic test_flush();
    int w = 0;
    send_byte(8'h11); send_byte(8'h12);
    flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h34;
    tick();
    flush = 1'b0; byte_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || instr_count !== CNT_W'(10)) begin
      errors++;
      $display("FAIL flush param: busy=%0b ov=%0b cnt=%0d, expected 0 0 10", busy, out_valid, instr_count);
    end
    exp_q.push_back(32'hE3A00006);
    send_byte(8'h10); send_byte(8'h06);
    wait_idle("after_flush");
    check_count("after_flush", 11);
    // Flush while a word is waiting: it is dropped uncounted.
    out_ready = 1'b0;
    send_byte(8'h04);
    while (!out_valid && w < 10) begin tick(); w++; end
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || instr_count !== CNT_W'(11)) begin
      errors++;
      $display("FAIL flush emit: busy=%0b ov=%0b cnt=%0d, expected 0 0 11", busy, out_valid, instr_count);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    out_ready = 1'b0;
    send_byte(8'h04);
    while (!out_valid && w < 10) begin tick(); w++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || instr_count !== '0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL reset mid: ov=%0b busy=%0b cnt=%0d er=%0b, expected all 0", out_valid, busy, instr_count, err_range);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    exp_q.push_back(32'hE3A00005);
    send_byte(8'h10); send_byte(8'h05);
    wait_idle("post_reset");
    check_count("post_reset", 1);
  endtask

  initial begin
    test_reset();
    test_bipush();
    test_wide();
    test_back_to_back();
    test_unknown();
    test_range();
    test_flush();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
